// File: rtl/ex_pipe_stage.sv
// ex_pipe_stage
// Execute-to-memory pipe for the 16-bit CPU. DEPTH register stages carry the
// ALU result, store data, destination register and memory/writeback control
// from the last ALU stage to the MEM stage. Supports stall, flush, per-stage
// valid tracking, an occupancy count and a two-port forwarding/hazard lookup
// over every in-flight stage.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid, stall, flush
//                         instruction valid, freeze all stages, kill in-flight
//   *_in                  ALU result, store data, rd and control from execute
//   out_valid, *_out      last-stage instruction; data and control masked to 0
//                         when the last stage is not valid
//   occupancy             number of valid stages
//   fwd_rs*_addr          forwarding query addresses
//   fwd_rs*_hit/_data     forwardable ALU result found for that query
//   load_hazard           a query matches an in-flight load (must stall)
module ex_pipe_stage #(
  parameter int DATA_W      = 16,
  parameter int REG_W       = 4,
  parameter int DEPTH       = 2,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [DATA_W-1:0]            alu_result_in,
  input  logic [DATA_W-1:0]            rs2_data_in,
  input  logic [REG_W-1:0]             rd_in,
  input  logic                         reg_write_in,
  input  logic                         mem_read_in,
  input  logic                         mem_write_in,
  input  logic                         mem_to_reg_in,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            alu_result_out,
  output logic [DATA_W-1:0]            rs2_data_out,
  output logic [REG_W-1:0]             rd_out,
  output logic                         reg_write_out,
  output logic                         mem_read_out,
  output logic                         mem_write_out,
  output logic                         mem_to_reg_out,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  input  logic [REG_W-1:0]             fwd_rs1_addr,
  input  logic [REG_W-1:0]             fwd_rs2_addr,
  output logic                         fwd_rs1_hit,
  output logic                         fwd_rs2_hit,
  output logic [DATA_W-1:0]            fwd_rs1_data,
  output logic [DATA_W-1:0]            fwd_rs2_data,
  output logic                         load_hazard
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int LAST  = DEPTH - 1;

  // Stage 0 is the youngest instruction, stage LAST feeds MEM.
  logic [DEPTH-1:0]  valid_r;
  logic [DEPTH-1:0]  reg_write_r;
  logic [DEPTH-1:0]  mem_read_r;
  logic [DEPTH-1:0]  mem_write_r;
  logic [DEPTH-1:0]  mem_to_reg_r;
  logic [DATA_W-1:0] alu_r [DEPTH];
  logic [DATA_W-1:0] rs2_r [DEPTH];
  logic [REG_W-1:0]  rd_r  [DEPTH];

  logic [REG_W-1:0]  fwd_addr_s [2];
  logic              fwd_hit_s  [2];
  logic              fwd_haz_s  [2];
  logic [DATA_W-1:0] fwd_data_s [2];
  logic [OCC_W-1:0]  occ_s;

  // Stage registers: reset > flush > stall > advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r      <= '0;
      reg_write_r  <= '0;
      mem_read_r   <= '0;
      mem_write_r  <= '0;
      mem_to_reg_r <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        alu_r[k] <= '0;
        rs2_r[k] <= '0;
        rd_r[k]  <= '0;
      end
    end else if (flush) begin
      // Data registers keep their contents; the cleared valid masks them.
      valid_r      <= '0;
      reg_write_r  <= '0;
      mem_read_r   <= '0;
      mem_write_r  <= '0;
      mem_to_reg_r <= '0;
    end else if (!stall) begin
      for (int k = LAST; k > 0; k--) begin
        valid_r[k]      <= valid_r[k-1];
        reg_write_r[k]  <= reg_write_r[k-1];
        mem_read_r[k]   <= mem_read_r[k-1];
        mem_write_r[k]  <= mem_write_r[k-1];
        mem_to_reg_r[k] <= mem_to_reg_r[k-1];
        alu_r[k]        <= alu_r[k-1];
        rs2_r[k]        <= rs2_r[k-1];
        rd_r[k]         <= rd_r[k-1];
      end
      // Control is qualified by in_valid so bubbles carry all-zero control.
      valid_r[0]      <= in_valid;
      reg_write_r[0]  <= in_valid & reg_write_in;
      mem_read_r[0]   <= in_valid & mem_read_in;
      mem_write_r[0]  <= in_valid & mem_write_in;
      mem_to_reg_r[0] <= in_valid & mem_to_reg_in;
      alu_r[0]        <= alu_result_in;
      rs2_r[0]        <= rs2_data_in;
      rd_r[0]         <= rd_in;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Occupancy: popcount of the stage valid bits.
  always_comb begin
    occ_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_s = occ_s + OCC_W'(valid_r[k]);
    end
  end

  assign fwd_addr_s[0] = fwd_rs1_addr;
  assign fwd_addr_s[1] = fwd_rs2_addr;

  // Forwarding lookup: scan oldest to youngest so the youngest candidate's
  // verdict is the one left standing. A load winner blocks older ALU matches.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      fwd_hit_s[p]  = 1'b0;
      fwd_haz_s[p]  = 1'b0;
      fwd_data_s[p] = '0;
      for (int k = LAST; k >= 0; k--) begin
        if (valid_r[k] && reg_write_r[k] && (rd_r[k] == fwd_addr_s[p]) &&
            !((ZERO_REG_EN != 0) && (fwd_addr_s[p] == '0))) begin
          if (mem_to_reg_r[k]) begin
            fwd_hit_s[p]  = 1'b0;
            fwd_haz_s[p]  = 1'b1;
            fwd_data_s[p] = '0;
          end else begin
            fwd_hit_s[p]  = 1'b1;
            fwd_haz_s[p]  = 1'b0;
            fwd_data_s[p] = alu_r[k];
          end
        end else begin
          fwd_hit_s[p]  = fwd_hit_s[p];
          fwd_haz_s[p]  = fwd_haz_s[p];
          fwd_data_s[p] = fwd_data_s[p];
        end
      end
    end
  end

  assign out_valid      = valid_r[LAST];
  assign alu_result_out = valid_r[LAST] ? alu_r[LAST] : '0;
  assign rs2_data_out   = valid_r[LAST] ? rs2_r[LAST] : '0;
  assign rd_out         = valid_r[LAST] ? rd_r[LAST]  : '0;
  assign reg_write_out  = valid_r[LAST] & reg_write_r[LAST];
  assign mem_read_out   = valid_r[LAST] & mem_read_r[LAST];
  assign mem_write_out  = valid_r[LAST] & mem_write_r[LAST];
  assign mem_to_reg_out = valid_r[LAST] & mem_to_reg_r[LAST];
  assign occupancy      = occ_s;

  assign fwd_rs1_hit  = fwd_hit_s[0];
  assign fwd_rs2_hit  = fwd_hit_s[1];
  assign fwd_rs1_data = fwd_data_s[0];
  assign fwd_rs2_data = fwd_data_s[1];
  assign load_hazard  = fwd_haz_s[0] | fwd_haz_s[1];

endmodule
